blob_locator: RTL and testbench

BLOB_LOCATOR -- requirements
Module: blob_locator

---
 rtl/blob_locator.sv | 179 +++++++++++++++++
 tb/tb_blob_locator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blob_locator.sv
`default_nettype none
// ============================================================================
// Module      : blob_locator
// Description : Per-frame foreground locator. Collects the coordinates of
//               flagged pixels between vertical-sync rising edges and, at each
//               frame boundary, reports either the median stored sample
//               (MODE 0) or the bounding-box centre (MODE 1), together with
//               the hit count, found and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module blob_locator #(
    parameter int COORD_W = 16,
    parameter int DEPTH   = 16,
    parameter int MODE    = 0,
    parameter int CNT_W   = 20
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               VGA_VS,
    input  logic               BINARY_FLAG,
    input  logic [COORD_W-1:0] H_CNT,
    input  logic [COORD_W-1:0] V_CNT,
    output logic [COORD_W-1:0] POINT_H,
    output logic [COORD_W-1:0] POINT_V,
    output logic               POINT_FOUND,
    output logic               POINT_VALID,
    output logic [CNT_W-1:0]   HIT_CNT,
    output logic               OVERFLOW
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SC_W  = IDX_W + 1;
    localparam logic [SC_W-1:0] c_depth_cnt = SC_W'(DEPTH);

    // Frame-boundary detection; vs_q resets high so a VS already high at
    // reset release is not mistaken for a rising edge.
    logic vs_q;
    logic w_edge;

    // Per-frame accumulators
    logic [SC_W-1:0]    cnt_q,   cnt_d;
    logic [CNT_W-1:0]   hits_q,  hits_d;
    logic               ovf_q,   ovf_d;
    logic [COORD_W-1:0] min_h_q, min_h_d, max_h_q, max_h_d;
    logic [COORD_W-1:0] min_v_q, min_v_d, max_v_q, max_v_d;

    // Sample storage (no reset: only entries written this frame are read)
    logic [2*COORD_W-1:0] mem_q [DEPTH];
    logic                 w_wr_en;
    logic [IDX_W-1:0]     w_wr_idx;

    // Result candidates computed from the frame just closing
    logic [COORD_W-1:0] w_res_h, w_res_v;

    // Registered outputs
    logic [COORD_W-1:0] point_h_q, point_v_q;
    logic               found_q, valid_q, ovf_out_q;
    logic [CNT_W-1:0]   hit_out_q;

    assign w_edge = VGA_VS & ~vs_q;

    // Accumulator next-state: restart on the edge first, so a pixel flagged
    // in the edge cycle lands in the fresh frame.
    always_comb begin
        cnt_d    = cnt_q;
        hits_d   = hits_q;
        ovf_d    = ovf_q;
        min_h_d  = min_h_q;
        max_h_d  = max_h_q;
        min_v_d  = min_v_q;
        max_v_d  = max_v_q;
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        if (w_edge) begin
            cnt_d   = '0;
            hits_d  = '0;
            ovf_d   = 1'b0;
            min_h_d = '1;
            max_h_d = '0;
            min_v_d = '1;
            max_v_d = '0;
        end
        if (BINARY_FLAG) begin
            if (cnt_d < c_depth_cnt) begin
                w_wr_en  = 1'b1;
                w_wr_idx = cnt_d[IDX_W-1:0];
                cnt_d    = cnt_d + SC_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
            if (hits_d != '1) hits_d = hits_d + CNT_W'(1);
            if (H_CNT < min_h_d) min_h_d = H_CNT;
            if (H_CNT > max_h_d) max_h_d = H_CNT;
            if (V_CNT < min_v_d) min_v_d = V_CNT;
            if (V_CNT > max_v_d) max_v_d = V_CNT;
        end
    end

    // Accumulator and sync-delay registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vs_q    <= 1'b1;
            cnt_q   <= '0;
            hits_q  <= '0;
            ovf_q   <= 1'b0;
            min_h_q <= '1;
            max_h_q <= '0;
            min_v_q <= '1;
            max_v_q <= '0;
        end else begin
            vs_q    <= VGA_VS;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            ovf_q   <= ovf_d;
            min_h_q <= min_h_d;
            max_h_q <= max_h_d;
            min_v_q <= min_v_d;
            max_v_q <= max_v_d;
        end
    end

    // Sample storage write port
    always_ff @(posedge CLK) begin
        if (w_wr_en) mem_q[w_wr_idx] <= {H_CNT, V_CNT};
    end

    generate
        if (MODE == 0) begin : g_median
            // n>>1 never exceeds DEPTH/2, so it always addresses a valid entry
            logic [2*COORD_W-1:0] w_mid;
            assign w_mid   = mem_q[cnt_q[IDX_W:1]];
            assign w_res_h = w_mid[2*COORD_W-1:COORD_W];
            assign w_res_v = w_mid[COORD_W-1:0];
        end else begin : g_centre
            // One extra bit keeps the carry of the sum before halving
            logic [COORD_W:0] w_sum_h, w_sum_v;
            assign w_sum_h = {1'b0, min_h_q} + {1'b0, max_h_q};
            assign w_sum_v = {1'b0, min_v_q} + {1'b0, max_v_q};
            assign w_res_h = COORD_W'(w_sum_h >> 1);
            assign w_res_v = COORD_W'(w_sum_v >> 1);
        end
    endgenerate

    // Result capture at each frame boundary; outputs hold in between
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            point_h_q <= '0;
            point_v_q <= '0;
            found_q   <= 1'b0;
            valid_q   <= 1'b0;
            hit_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            valid_q <= w_edge;
            if (w_edge) begin
                if (hits_q != '0) begin
                    point_h_q <= w_res_h;
                    point_v_q <= w_res_v;
                    found_q   <= 1'b1;
                end else begin
                    point_h_q <= '0;
                    point_v_q <= '0;
                    found_q   <= 1'b0;
                end
                hit_out_q <= hits_q;
                ovf_out_q <= ovf_q;
            end
        end
    end

    assign POINT_H     = point_h_q;
    assign POINT_V     = point_v_q;
    assign POINT_FOUND = found_q;
    assign POINT_VALID = valid_q;
    assign HIT_CNT     = hit_out_q;
    assign OVERFLOW    = ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_blob_locator.sv
`default_nettype none
// ============================================================================
// Module      : tb_blob_locator
// Description : Directed self-checking bench for blob_locator. One median
//               instance (MODE 0) and one centre instance (MODE 1) share the
//               same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blob_locator;

    logic        clk;
    logic        rst_n;
    logic        vs;
    logic        flag;
    logic [15:0] h;
    logic [15:0] v;

    logic [15:0] m_h, m_v, c_h, c_v;
    logic        m_found, m_valid, m_ovf, c_found, c_valid, c_ovf;
    logic [19:0] m_hits, c_hits;

    int checks   = 0;
    int failures = 0;

    blob_locator #(.COORD_W(16), .DEPTH(16), .MODE(0), .CNT_W(20)) u_med (
        .CLK(clk), .RST_N(rst_n), .VGA_VS(vs), .BINARY_FLAG(flag),
        .H_CNT(h), .V_CNT(v),
        .POINT_H(m_h), .POINT_V(m_v), .POINT_FOUND(m_found),
        .POINT_VALID(m_valid), .HIT_CNT(m_hits), .OVERFLOW(m_ovf)
    );

    blob_locator #(.COORD_W(16), .DEPTH(16), .MODE(1), .CNT_W(20)) u_ctr (
        .CLK(clk), .RST_N(rst_n), .VGA_VS(vs), .BINARY_FLAG(flag),
        .H_CNT(h), .V_CNT(v),
        .POINT_H(c_h), .POINT_V(c_v), .POINT_FOUND(c_found),
        .POINT_VALID(c_valid), .HIT_CNT(c_hits), .OVERFLOW(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] ph, input logic [15:0] pv);
        flag = 1'b1; h = ph; v = pv;
        tick();
        flag = 1'b0;
    endtask

    // Raise VS for two cycles: the first is the edge cycle, the second must not re-trigger
    task automatic close_frame();
        vs = 1'b1;
        tick();
    endtask

    task automatic end_frame();
        tick();
        chk("valid_drops", {31'b0, m_valid}, 32'd0);
        vs = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; vs = 1'b0; flag = 1'b0; h = '0; v = '0;
        tick(); tick();
        chk("rst_h",     {16'b0, m_h}, 32'd0);
        chk("rst_v",     {16'b0, m_v}, 32'd0);
        chk("rst_found", {31'b0, m_found}, 32'd0);
        chk("rst_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_hits",  {12'b0, m_hits}, 32'd0);
        chk("rst_ovf",   {31'b0, m_ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Five hits on one row
        for (int i = 0; i < 5; i++) pix(16'(10 + i), 16'd20);
        chk("idle_valid", {31'b0, m_valid}, 32'd0);
        close_frame();
        chk("f1_valid", {31'b0, m_valid}, 32'd1);
        chk("f1_h",     {16'b0, m_h}, 32'd12);
        chk("f1_v",     {16'b0, m_v}, 32'd20);
        chk("f1_hits",  {12'b0, m_hits}, 32'd5);
        chk("f1_found", {31'b0, m_found}, 32'd1);
        chk("f1_ovf",   {31'b0, m_ovf}, 32'd0);
        chk("f1_ctr_h", {16'b0, c_h}, 32'd12);
        chk("f1_ctr_v", {16'b0, c_v}, 32'd20);
        end_frame();
        chk("f1_hold_h", {16'b0, m_h}, 32'd12);
        chk("f1_hold_hits", {12'b0, m_hits}, 32'd5);

        // Forty hits overflow the 16-entry store; median is the 9th hit
        for (int i = 0; i < 40; i++) pix(16'(i), 16'(100 + i));
        close_frame();
        chk("f2_valid", {31'b0, m_valid}, 32'd1);
        chk("f2_ovf",   {31'b0, m_ovf}, 32'd1);
        chk("f2_hits",  {12'b0, m_hits}, 32'd40);
        chk("f2_h",     {16'b0, m_h}, 32'd8);
        chk("f2_v",     {16'b0, m_v}, 32'd108);
        chk("f2_ctr_h", {16'b0, c_h}, 32'd19);
        chk("f2_ctr_v", {16'b0, c_v}, 32'd119);
        end_frame();

        // Three-point frame: centre vs median
        pix(16'd100, 16'd50);
        pix(16'd300, 16'd50);
        pix(16'd200, 16'd90);
        close_frame();
        chk("f3_ctr_h", {16'b0, c_h}, 32'd200);
        chk("f3_ctr_v", {16'b0, c_v}, 32'd70);
        chk("f3_ctr_found", {31'b0, c_found}, 32'd1);
        chk("f3_med_h", {16'b0, m_h}, 32'd300);
        chk("f3_med_v", {16'b0, m_v}, 32'd50);
        chk("f3_ovf",   {31'b0, m_ovf}, 32'd0);
        end_frame();

        // Empty frame after a non-empty one
        tick(); tick();
        close_frame();
        chk("f4_valid", {31'b0, m_valid}, 32'd1);
        chk("f4_h",     {16'b0, m_h}, 32'd0);
        chk("f4_v",     {16'b0, m_v}, 32'd0);
        chk("f4_found", {31'b0, m_found}, 32'd0);
        chk("f4_hits",  {12'b0, m_hits}, 32'd0);
        chk("f4_ctr_h", {16'b0, c_h}, 32'd0);
        end_frame();

        // Pixel on the edge cycle belongs to the next frame
        pix(16'd1, 16'd1);
        pix(16'd5, 16'd5);
        vs = 1'b1; flag = 1'b1; h = 16'd7; v = 16'd3;
        tick();
        flag = 1'b0;
        chk("f5_hits", {12'b0, m_hits}, 32'd2);
        chk("f5_h",    {16'b0, m_h}, 32'd5);
        chk("f5_ctr_h", {16'b0, c_h}, 32'd3);
        end_frame();
        close_frame();
        chk("f6_hits", {12'b0, m_hits}, 32'd1);
        chk("f6_h",    {16'b0, m_h}, 32'd7);
        chk("f6_v",    {16'b0, m_v}, 32'd3);
        chk("f6_ctr_h", {16'b0, c_h}, 32'd7);
        chk("f6_ctr_v", {16'b0, c_v}, 32'd3);
        end_frame();

        // Centre sum must keep its carry near full scale
        pix(16'hFFFF, 16'hFFFE);
        pix(16'hFFFD, 16'hFFFF);
        close_frame();
        chk("f7_ctr_h", {16'b0, c_h}, 32'h0000FFFE);
        chk("f7_ctr_v", {16'b0, c_v}, 32'h0000FFFE);
        end_frame();

        // VS held high across reset release: no frame edge
        rst_n = 1'b0; vs = 1'b1;
        tick();
        chk("rst2_h", {16'b0, m_h}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst2_valid_a", {31'b0, m_valid}, 32'd0);
        tick();
        chk("rst2_valid_b", {31'b0, m_valid}, 32'd0);
        vs = 1'b0;
        tick();

        // Reset mid-frame discards earlier hits
        pix(16'd30, 16'd30);
        pix(16'd31, 16'd31);
        pix(16'd32, 16'd32);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pix(16'd50, 16'd60);
        pix(16'd52, 16'd62);
        close_frame();
        chk("f8_valid", {31'b0, m_valid}, 32'd1);
        chk("f8_hits",  {12'b0, m_hits}, 32'd2);
        chk("f8_h",     {16'b0, m_h}, 32'd52);
        chk("f8_v",     {16'b0, m_v}, 32'd62);
        chk("f8_ctr_h", {16'b0, c_h}, 32'd51);
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
